instr_mem_responder: RTL and testbench

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

---
 rtl/instr_mem_responder.sv | 136 +++++++++++++
 tb/tb_instr_mem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder for a fetch port.
//
// A request is accepted when req_valid & req_ready. After acceptance the
// responder waits WAIT_CYCLES + 1 cycles, then registers the response and
// holds it until the consumer takes it. A request whose address is
// misaligned or beyond the stored image returns a NOP with rsp_fault set.
// flush aborts an in-flight request, and no response is produced for it.
// The program image is written through the ld_* port, in any state.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   fetch request handshake
//   req_addr              64-bit byte address (PC)
//   rsp_valid/rsp_ready   response handshake
//   rsp_instr             fetched word (NOP on fault)
//   rsp_addr              req_addr echoed for this response
//   rsp_fault             misaligned or out-of-range fetch
//   flush                 abort in-flight request / block acceptance
//   ld_en/ld_addr/ld_data program-load write port (word indexed)
module instr_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [63:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_instr,
  output logic [63:0]   rsp_addr,
  output logic          rsp_fault,
  input  logic          flush,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH_WORDS) << 2;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic        sample;

  logic [31:0] rsp_instr_q;
  logic [63:0] rsp_addr_q;
  logic        rsp_fault_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          fault;
  logic [AW-1:0] word_idx;

  // Full 64-bit compare so high address bits can never alias into range.
  assign fault    = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIMIT);
  assign word_idx = addr_q[AW+1:2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    sample    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = !flush;
        if (req_valid && !flush) begin
          addr_d  = req_addr;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = StWait;
        end
      end
      StWait: begin
        // Counter walks down to 0; the edge after it reaches 0 enters RESP,
        // giving WAIT_CYCLES + 1 cycles between acceptance and the sample.
        if (flush) begin
          cnt_d   = 4'd0;
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          sample  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        // Gate with flush so an aborted response is never seen as valid.
        rsp_valid = !flush;
        if (flush || rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      addr_q      <= 64'd0;
      rsp_instr_q <= 32'd0;
      rsp_addr_q  <= 64'd0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (sample) begin
        rsp_addr_q  <= addr_q;
        rsp_fault_q <= fault;
        // A load to the same word on this edge is not yet visible here.
        rsp_instr_q <= fault ? NOP_INSTR : mem[word_idx];
      end
    end
  end

  // Program image survives reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  assign rsp_instr = rsp_instr_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: a WAIT_CYCLES=1 instance carries
// most of the sequence, a WAIT_CYCLES=0 instance checks the short latency.
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_valid0;
  logic        req_ready, req_ready0;
  logic [63:0] req_addr;
  logic        rsp_valid, rsp_valid0;
  logic        rsp_ready, rsp_ready0;
  logic [31:0] rsp_instr, rsp_instr0;
  logic [63:0] rsp_addr, rsp_addr0;
  logic        rsp_fault, rsp_fault0;
  logic        flush;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_addr(rsp_addr), .rsp_fault(rsp_fault),
    .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  instr_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_addr(req_addr), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_instr(rsp_instr0), .rsp_addr(rsp_addr0), .rsp_fault(rsp_fault0),
    .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs and samples sit 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then wait for the WAIT_CYCLES=1 sample edge.
  task automatic fetch(input logic [63:0] a);
    req_addr  = a;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [31:0] words [4];
    words = '{32'h0000_0013, 32'h0000_0093, 32'h0000_0113, 32'h0000_0193};

    reset = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; req_addr = 64'd0;
    rsp_ready = 1'b1; rsp_ready0 = 1'b1; flush = 1'b0;
    ld_en = 1'b0; ld_addr = 10'd0; ld_data = 32'd0;
    #12;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_instr", rsp_instr, 0);
    chk("reset_rsp_addr",  rsp_addr, 0);
    chk("reset_rsp_fault", rsp_fault, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Program load: four words plus the last word of the image.
    for (int i = 0; i < 4; i++) begin
      ld_en = 1'b1; ld_addr = 10'(i); ld_data = words[i];
      tick();
    end
    ld_addr = 10'd1023; ld_data = 32'hCAFE_F00D;
    tick();
    ld_en = 1'b0;

    // Basic fetch, latency of two edges after acceptance.
    chk("idle_req_ready", req_ready, 1);
    req_addr = 64'h8; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("lat_edge0_valid", rsp_valid, 0);
    chk("lat_edge0_ready", req_ready, 0);
    tick();
    chk("lat_edge1_valid", rsp_valid, 0);
    tick();
    chk("lat_edge2_valid", rsp_valid, 1);
    chk("fetch8_instr", rsp_instr, 32'h0000_0113);
    chk("fetch8_addr",  rsp_addr, 64'h8);
    chk("fetch8_fault", rsp_fault, 0);
    tick();
    chk("fetch8_done_valid", rsp_valid, 0);
    chk("fetch8_done_ready", req_ready, 1);

    // Faults and range boundaries.
    fetch(64'h6);
    chk("mis_fault", rsp_fault, 1);
    chk("mis_instr", rsp_instr, 32'h0000_0013);
    chk("mis_addr",  rsp_addr, 64'h6);
    tick();
    fetch(64'h1000);
    chk("oor_fault", rsp_fault, 1);
    chk("oor_instr", rsp_instr, 32'h0000_0013);
    tick();
    fetch(64'h1_0000_0000);
    chk("oor64_fault", rsp_fault, 1);
    chk("oor64_instr", rsp_instr, 32'h0000_0013);
    tick();
    fetch(64'hFFC);
    chk("last_fault", rsp_fault, 0);
    chk("last_instr", rsp_instr, 32'hCAFE_F00D);
    tick();

    // Backpressure: response held for five cycles.
    rsp_ready = 1'b0;
    fetch(64'hC);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_instr", rsp_instr, 32'h0000_0193);
      chk("bp_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_ready", req_ready, 1);

    // Flush one cycle after acceptance: the request is dropped.
    req_addr = 64'h0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    chk("flush_ready_blocked", req_ready, 0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("flush_no_rsp", rsp_valid, 0);
      tick();
    end
    chk("flush_idle_ready", req_ready, 1);
    fetch(64'h4);
    chk("post_flush_valid", rsp_valid, 1);
    chk("post_flush_instr", rsp_instr, 32'h0000_0093);
    tick();

    // Load colliding with the sample edge returns old data.
    req_addr = 64'h8; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    ld_en = 1'b1; ld_addr = 10'd2; ld_data = 32'hDEAD_BEEF;
    tick();
    ld_en = 1'b0;
    chk("collide_valid", rsp_valid, 1);
    chk("collide_instr", rsp_instr, 32'h0000_0113);
    tick();
    fetch(64'h8);
    chk("refetch_instr", rsp_instr, 32'hDEAD_BEEF);
    tick();

    // Reset during WAIT discards the request; memory survives.
    req_addr = 64'hC; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_wait_valid", rsp_valid, 0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rel_ready", req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("rst_no_stale", rsp_valid, 0);
      tick();
    end
    fetch(64'hC);
    chk("mem_kept_instr", rsp_instr, 32'h0000_0193);
    tick();

    // WAIT_CYCLES=0 instance: response one edge after acceptance.
    req_addr = 64'h4; req_valid0 = 1'b1;
    tick();
    req_valid0 = 1'b0;
    chk("w0_edge0_valid", rsp_valid0, 0);
    tick();
    chk("w0_edge1_valid", rsp_valid0, 1);
    chk("w0_instr", rsp_instr0, 32'h0000_0093);
    chk("w0_fault", rsp_fault0, 0);
    tick();
    chk("w0_done_valid", rsp_valid0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
